// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited in-order fetch, prefetch FIFO, redirect/flush.
// Optional perf counters (FetchCount/DropCount/StallCount) are enabled by defining FETCH_PERF_EN.
module fetch_unit #(
    parameter int                INSTR_W  = 26,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               PCSrc,
    input  logic [ADDR_W-1:0]  BranchTarget,
    output logic               IMemReq,
    output logic [ADDR_W-1:0]  IMemAddr,
    input  logic               IMemGnt,
    input  logic [INSTR_W-1:0] IMemRData,
    input  logic               IMemRValid,
    output logic [INSTR_W-1:0] Instr,
    output logic [ADDR_W-1:0]  PCF,
    output logic               InstrValid,
`ifdef FETCH_PERF_EN
    output logic [31:0]        FetchCount,
    output logic [31:0]        DropCount,
    output logic [31:0]        StallCount,
`endif
    input  logic               InstrReady
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [ADDR_W-1:0]  fetch_pc;
    logic [INSTR_W-1:0] fifo_instr [DEPTH];
    logic [ADDR_W-1:0]  fifo_pc    [DEPTH];
    logic [ADDR_W-1:0]  aq_pc      [DEPTH];
    logic [AW-1:0]      rd_ptr, wr_ptr, aq_rd, aq_wr;
    logic [CW-1:0]      fill, outstanding, drop;
    logic [CW:0]        credit_used;
    logic               accept, resp, push, pop;

    // Requests already in flight hold a FIFO slot, so fill+outstanding bounds the credit.
    assign credit_used = {1'b0, fill} + {1'b0, outstanding};
    assign IMemReq     = !reset && !PCSrc && (credit_used < (CW+1)'(DEPTH));
    assign IMemAddr    = fetch_pc;

    assign accept = IMemReq && IMemGnt;
    assign resp   = IMemRValid;
    assign push   = resp && !PCSrc && (drop == '0);
    assign pop    = InstrValid && InstrReady && !PCSrc;

    assign InstrValid = (fill != '0);
    assign Instr      = InstrValid ? fifo_instr[rd_ptr] : '0;
    assign PCF        = InstrValid ? fifo_pc[rd_ptr]    : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            aq_rd       <= '0;
            aq_wr       <= '0;
            fill        <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else if (PCSrc) begin
            // Every request still in flight (minus one returning now) belongs to the old path.
            fetch_pc    <= BranchTarget;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            aq_rd       <= '0;
            aq_wr       <= '0;
            fill        <= '0;
            outstanding <= outstanding - CW'(resp);
            drop        <= outstanding - CW'(resp);
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + ADDR_W'(4);
                aq_wr    <= aq_wr + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                aq_rd  <= aq_rd + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fill        <= fill + CW'(push) - CW'(pop);
            outstanding <= outstanding + CW'(accept) - CW'(resp);
            if (resp && (drop != '0))
                drop <= drop - 1'b1;
        end
    end

    // Storage carries no reset; pointers and fill decide what is visible.
    always_ff @(posedge clk) begin
        if (accept)
            aq_pc[aq_wr] <= fetch_pc;
        if (push) begin
            fifo_instr[wr_ptr] <= IMemRData;
            fifo_pc[wr_ptr]    <= aq_pc[aq_rd];
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (fill == CW'(DEPTH))));
    a_counters_bounded: assert property (@(posedge clk) disable iff (reset)
        (outstanding <= CW'(DEPTH)) && (drop <= CW'(DEPTH)) && (drop <= outstanding));

`ifdef FETCH_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        if (!en || (v == 32'hFFFF_FFFF))
            return v;
        return v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            FetchCount <= '0;
            DropCount  <= '0;
            StallCount <= '0;
        end else begin
            FetchCount <= sat_inc(FetchCount, accept);
            DropCount  <= sat_inc(DropCount, resp && !push);
            StallCount <= sat_inc(StallCount, InstrValid && !InstrReady);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit against a transaction-level queue model.
module tb_fetch_unit;

    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset, PCSrc, IMemGnt, IMemRValid, InstrReady;
    logic [31:0] BranchTarget, IMemAddr, PCF;
    logic [25:0] IMemRData, Instr;
    logic        IMemReq, InstrValid;
`ifdef FETCH_PERF_EN
    logic [31:0] FetchCount, DropCount, StallCount;
`endif

    fetch_unit #(.INSTR_W(26), .ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .PCSrc(PCSrc), .BranchTarget(BranchTarget),
        .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemGnt(IMemGnt),
        .IMemRData(IMemRData), .IMemRValid(IMemRValid),
        .Instr(Instr), .PCF(PCF), .InstrValid(InstrValid),
`ifdef FETCH_PERF_EN
        .FetchCount(FetchCount), .DropCount(DropCount), .StallCount(StallCount),
`endif
        .InstrReady(InstrReady)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [25:0] memfn(input logic [31:0] a);
        logic [31:0] t;
        t = (a >> 2) ^ 32'h02A5_C3F1;
        return t[25:0];
    endfunction

    // Memory model: in-order responses, each at least `lat` cycles after its accept.
    typedef struct { logic [25:0] data; int due; } mr_t;
    mr_t pend[$];
    int  last_due = 0;
    int  cyc = 0;

    // Reference model: fetched-but-unreturned addresses (with a "wrong path" flag) and
    // the queue of instructions decode will see.
    typedef struct { logic [31:0] addr; bit stale; } fl_t;
    fl_t         inflight[$];
    logic [31:0] mq[$];
    logic [31:0] mpc = RESET_PC;
    int          m_fetch = 0, m_drop = 0, m_stall = 0;
    bit          post_rst = 1'b0;

    // Observations from the most recent step.
    bit          acc_seen, pop_seen, obs_req;
    logic [31:0] pop_pc, obs_addr;
    logic [31:0] obs_fetch, obs_dropc, obs_stall;

    task automatic step(input bit rst_i, input bit pcsrc_i, input logic [31:0] tgt_i,
                        input bit ready_i, input bit gnt_i, input int lat_i);
        bit          rv, exp_req, exp_valid, acc_dut;
        logic [31:0] dut_addr;
        fl_t         f;
        @(negedge clk);
        reset = rst_i; PCSrc = pcsrc_i; BranchTarget = tgt_i;
        InstrReady = ready_i; IMemGnt = gnt_i;
        rv = (pend.size() > 0) && (pend[0].due <= cyc);
        IMemRValid = rv;
        IMemRData  = rv ? pend[0].data : 26'h0;
        #1;
        exp_req   = !rst_i && !pcsrc_i && ((mq.size() + inflight.size()) < DEPTH);
        exp_valid = (mq.size() > 0);
        check_eq("imemreq", IMemReq, exp_req);
        if (!rst_i) begin
            if (exp_req) check_eq("imemaddr", IMemAddr, mpc);
            check_eq("instrvalid", InstrValid, exp_valid);
            if (exp_valid) begin
                check_eq("pcf", PCF, mq[0]);
                check_eq("instr", Instr, memfn(mq[0]));
            end
            if (post_rst) begin
                check_eq("rst_addr", IMemAddr, RESET_PC);
                check_eq("rst_instr", Instr, 0);
                check_eq("rst_pcf", PCF, 0);
            end
`ifdef FETCH_PERF_EN
            check_eq("fetchcount", FetchCount, m_fetch);
            check_eq("dropcount", DropCount, m_drop);
            check_eq("stallcount", StallCount, m_stall);
            obs_fetch = FetchCount; obs_dropc = DropCount; obs_stall = StallCount;
`endif
        end
        acc_dut  = IMemReq && IMemGnt;
        dut_addr = IMemAddr;
        obs_req  = IMemReq;
        obs_addr = IMemAddr;
        acc_seen = acc_dut;
        pop_seen = !rst_i && !pcsrc_i && exp_valid && ready_i;
        pop_pc   = exp_valid ? mq[0] : 32'h0;
        @(posedge clk);
        if (rst_i) begin
            pend.delete(); last_due = cyc;
            inflight.delete(); mq.delete();
            mpc = RESET_PC; m_fetch = 0; m_drop = 0; m_stall = 0;
        end else begin
            if (rv) void'(pend.pop_front());
            if (acc_dut) begin
                last_due = (cyc + lat_i > last_due + 1) ? cyc + lat_i : last_due + 1;
                pend.push_back('{data: memfn(dut_addr), due: last_due});
            end
            if (exp_valid && !ready_i) m_stall++;
            if (pcsrc_i) begin
                if (rv && inflight.size() > 0) begin
                    void'(inflight.pop_front());
                    m_drop++;
                end
                for (int i = 0; i < inflight.size(); i++) inflight[i].stale = 1'b1;
                mq.delete();
                mpc = tgt_i;
            end else begin
                if (exp_valid && ready_i) void'(mq.pop_front());
                if (rv && inflight.size() > 0) begin
                    f = inflight.pop_front();
                    if (f.stale) m_drop++;
                    else mq.push_back(f.addr);
                end
                if (exp_req && gnt_i) begin
                    inflight.push_back('{addr: mpc, stale: 1'b0});
                    mpc = mpc + 32'd4;
                    m_fetch++;
                end
            end
        end
        post_rst = rst_i;
        cyc++;
    endtask

    task automatic do_reset();
        step(1, 0, 0, 1, 1, 1);
        step(1, 0, 0, 1, 1, 1);
    endtask

    int n_acc, start_cyc, pop_cyc;
    bit got_pop;

    initial begin
        reset = 1'b1; PCSrc = 1'b0; BranchTarget = '0; InstrReady = 1'b0;
        IMemGnt = 1'b0; IMemRValid = 1'b0; IMemRData = '0;

        // Streaming at latency 1: first instruction (PC 0) two cycles after the first accept.
        do_reset();
        start_cyc = cyc; got_pop = 0; pop_cyc = 0;
        for (int i = 0; i < 30; i++) begin
            step(0, 0, 0, 1, 1, 1);
            if (pop_seen && !got_pop) begin
                got_pop = 1; pop_cyc = cyc - 1;
                check_eq("first_pcf", pop_pc, 32'h0);
            end
        end
        check_eq("first_pop_seen", got_pop, 1);
        check_eq("start_latency", pop_cyc - start_cyc, 2);

        // Stall for 10 cycles: credits allow exactly DEPTH accepts.
        do_reset();
        n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 1, 1);
            n_acc += int'(acc_seen);
        end
        check_eq("stall_accepts", n_acc, DEPTH);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 1, 1);

        // Latency 3, three in flight, redirect to 0x100: old responses are dropped.
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 3);
        step(0, 1, 32'h100, 1, 1, 3);
        got_pop = 0;
        for (int i = 0; i < 20 && !got_pop; i++) begin
            step(0, 0, 0, 1, 1, 3);
            if (pop_seen) begin
                got_pop = 1;
                check_eq("redir_first_pcf", pop_pc, 32'h100);
            end
        end
        check_eq("redir_pop_seen", got_pop, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, 3);
        step(0, 0, 0, 1, 1, 3);
`ifdef FETCH_PERF_EN
        check_eq("perf_drop3", obs_dropc, 3);
        check_eq("perf_stall10", obs_stall, 10);
        check_eq("perf_fetch_model", obs_fetch, m_fetch);
`endif

        // Fetch address wraps at the top of the address space.
        do_reset();
        step(0, 1, 32'hFFFF_FFFC, 1, 1, 1);
        step(0, 0, 0, 1, 1, 1);
        check_eq("wrap_req", obs_req, 1);
        check_eq("wrap_addr0", obs_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 1, 1, 1);
        check_eq("wrap_addr1", obs_addr, 32'h0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 1, 1);

        // Randomized traffic: redirects (incl. back-to-back), stalls, grant gaps, latency, resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            bit r, p;
            tgt = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hC);
            r = ($urandom_range(0, 299) == 0);
            p = ($urandom_range(0, 14) == 0);
            step(r, p, tgt, $urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0,
                 $urandom_range(1, 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
